// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and digit-search helpers for the seven-segment scan driver.
// Helpers work on a 16-bit mask, which is the largest supported digit count.
package seg_scan_ctrl_pkg;

    localparam int               SEG_W   = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b000_0000;

    // Returns {wrap, idx}: the lowest set index above cur, or wrap=1 with the lowest set index.
    function automatic logic [4:0] next_en(input logic [15:0] mask, input logic [3:0] cur);
        logic [4:0] res;
        logic [3:0] low;
        res = {1'b1, 4'd0};
        low = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                low = 4'(i);
                if (4'(i) > cur) begin
                    res = {1'b0, 4'(i)};
                end
            end
        end
        if (res[4]) begin
            res[3:0] = low;
        end
        return res;
    endfunction

    function automatic logic [3:0] first_en(input logic [15:0] mask);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// Slot timer: free-running slot counter, slot-end strobe and the brightness lit window.
// Brightness is captured on the slot-end cycle so it applies to the whole next slot.
module seg_slot_timer
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_bright,
    output logic       o_slot_end,
    output logic       o_lit
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW    = CNT_W + 4;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [PW-1:0]    LIT_SPAN = PW'(SCAN_DIV - BLANK_CYC);
    localparam logic [PW-1:0]    BLANK    = PW'(BLANK_CYC);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]       bright_q, bright_d;
    logic [PW-1:0]    win_len;
    logic [PW-1:0]    cnt_ext;

    always_comb begin
        o_slot_end = (slot_cnt_q == CNT_MAX);
        slot_cnt_d = o_slot_end ? '0 : slot_cnt_q + CNT_W'(1);
        bright_d   = o_slot_end ? i_bright : bright_q;
        // Product never exceeds SCAN_DIV*16, so PW bits hold it exactly.
        win_len    = (LIT_SPAN * PW'({1'b0, bright_q} + 5'd1)) >> 4;
        cnt_ext    = {4'b0000, slot_cnt_q};
        o_lit      = (cnt_ext >= BLANK) && ((cnt_ext - BLANK) < win_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            bright_q   <= 4'd0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            bright_q   <= bright_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan driver: digit pointer, frame shadow registers,
// registered output muxing with anti-ghost blanking, brightness PWM and enable polarity.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int  NUM_DIG     = 6,
    parameter int  SCAN_DIV    = 50000,
    parameter int  BLANK_CYC   = 500,
    parameter int  ENB_ACT_LOW = 1,
    localparam int IDX_W       = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEG_W*NUM_DIG-1:0] i_dig_seg,
    input  logic [NUM_DIG-1:0]       i_dp,
    input  logic [NUM_DIG-1:0]       i_dig_en,
    input  logic [3:0]               i_bright,
    input  logic                     i_disp_on,
    output logic [SEG_W-1:0]         o_seg,
    output logic                     o_seg_dp,
    output logic [NUM_DIG-1:0]       o_seg_enb,
    output logic [IDX_W-1:0]         o_digit_idx,
    output logic                     o_frame_tick
);

    localparam logic [NUM_DIG-1:0] ENB_OFF = (ENB_ACT_LOW != 0) ? '1 : '0;

    logic slot_end;
    logic lit;

    seg_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_bright   (i_bright),
        .o_slot_end (slot_end),
        .o_lit      (lit)
    );

    logic [IDX_W-1:0]         dig_q, dig_d;
    logic [SEG_W*NUM_DIG-1:0] seg_sh_q, seg_sh_d;
    logic [NUM_DIG-1:0]       dp_sh_q, dp_sh_d;
    logic [NUM_DIG-1:0]       en_sh_q, en_sh_d;
    logic [SEG_W-1:0]         seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic [NUM_DIG-1:0]       enb_q, enb_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     tick_q, tick_d;

    logic [SEG_W-1:0]   seg_arr [NUM_DIG];
    logic [4:0]         adv;
    logic               drive;
    logic [NUM_DIG-1:0] enb_act;

    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_seg_arr
        assign seg_arr[gi] = seg_sh_q[SEG_W*gi +: SEG_W];
    end

    always_comb begin
        adv      = next_en(16'(en_sh_q), 4'(dig_q));
        dig_d    = dig_q;
        seg_sh_d = seg_sh_q;
        dp_sh_d  = dp_sh_q;
        en_sh_d  = en_sh_q;
        tick_d   = 1'b0;
        if (slot_end) begin
            if (adv[4]) begin
                // Frame boundary: snapshot all inputs at once so a frame never tears.
                seg_sh_d = i_dig_seg;
                dp_sh_d  = i_dp;
                en_sh_d  = i_dig_en;
                dig_d    = IDX_W'(first_en(16'(i_dig_en)));
                tick_d   = 1'b1;
            end else begin
                dig_d = IDX_W'(adv[3:0]);
            end
        end

        drive   = lit && i_disp_on && en_sh_q[dig_q];
        enb_act = NUM_DIG'(1) << dig_q;
        seg_d   = drive ? seg_arr[dig_q] : SEG_OFF;
        dp_d    = drive && dp_sh_q[dig_q];
        enb_d   = ENB_OFF;
        if (drive) begin
            enb_d = (ENB_ACT_LOW != 0) ? ~enb_act : enb_act;
        end
        // Index is delayed with the outputs so it names the digit being shown.
        idx_d   = dig_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q    <= '0;
            seg_sh_q <= '0;
            dp_sh_q  <= '0;
            en_sh_q  <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b0;
            enb_q    <= ENB_OFF;
            idx_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            dig_q    <= dig_d;
            seg_sh_q <= seg_sh_d;
            dp_sh_q  <= dp_sh_d;
            en_sh_q  <= en_sh_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            enb_q    <= enb_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_seg_dp     = dp_q;
    assign o_seg_enb    = enb_q;
    assign o_digit_idx  = idx_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIG=6, SCAN_DIV=8, BLANK_CYC=2, active-low enables.
module tb_seg_scan_ctrl;

    localparam int ND = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [41:0]   i_dig_seg;
    logic [5:0]    i_dp;
    logic [5:0]    i_dig_en;
    logic [3:0]    i_bright;
    logic          i_disp_on;
    logic [6:0]    o_seg;
    logic          o_seg_dp;
    logic [5:0]    o_seg_enb;
    logic [2:0]    o_digit_idx;
    logic          o_frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIG     (ND),
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .ENB_ACT_LOW (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_dig_seg    (i_dig_seg),
        .i_dp         (i_dp),
        .i_dig_en     (i_dig_en),
        .i_bright     (i_bright),
        .i_disp_on    (i_disp_on),
        .o_seg        (o_seg),
        .o_seg_dp     (o_seg_dp),
        .o_seg_enb    (o_seg_enb),
        .o_digit_idx  (o_digit_idx),
        .o_frame_tick (o_frame_tick)
    );

    typedef struct {
        logic [5:0]  en;
        logic [3:0]  bright;
        logic        disp;
        int          nslots;
        logic [23:0] order;
        int          lit;
    } vec_t;

    vec_t vecs [8];

    logic [17:0] obs;
    assign obs = {o_frame_tick, o_digit_idx, o_seg_enb, o_seg_dp, o_seg};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got tick/idx/enb/dp/seg=%b/%0d/%b/%b/%h required %b/%0d/%b/%b/%h",
                     name, act[17], act[16:14], act[13:8], act[7], act[6:0],
                     exp[17], exp[16:14], exp[13:8], exp[7], exp[6:0]);
        end
    endtask

    function automatic logic [6:0] seg_of(input int k);
        logic [6:0] one;
        one = 7'h01;
        return one << k;
    endfunction

    function automatic logic [17:0] exp_vec(input int dig, input bit lit, input bit tick,
                                            input logic [6:0] seg, input logic dp);
        logic [5:0] enb;
        logic [6:0] s;
        logic       d;
        logic [5:0] one;
        one = 6'b000001;
        enb = 6'h3F;
        s   = 7'h00;
        d   = 1'b0;
        if (lit) begin
            enb = ~(one << dig);
            s   = seg;
            d   = dp;
        end
        return {tick, 3'(dig), enb, d, s};
    endfunction

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        step();
        while (o_frame_tick !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (o_frame_tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: frame_tick not seen within 200 clk, got 0 required 1", name);
        end
    endtask

    // After reset release: 7 dark cycles, then the 8th carries the first frame tick.
    task automatic check_after_reset(input string name);
        for (int j = 1; j <= 8; j++) begin
            step();
            check($sformatf("%s_j%0d", name, j), obs, exp_vec(0, 0, j == 8, 7'h00, 1'b0));
        end
    endtask

    initial begin
        for (int k = 0; k < ND; k++) i_dig_seg[7*k +: 7] = seg_of(k);
        i_dp      = 6'b001010;
        i_dig_en  = 6'h3F;
        i_bright  = 4'd15;
        i_disp_on = 1'b1;

        vecs[0] = '{6'h3F, 4'd15, 1'b1, 6, 24'h543210, 6};
        vecs[1] = '{6'h25, 4'd15, 1'b1, 3, 24'h000520, 6};
        vecs[2] = '{6'h3F, 4'd5,  1'b1, 6, 24'h543210, 2};
        vecs[3] = '{6'h12, 4'd0,  1'b1, 2, 24'h000041, 0};
        vecs[4] = '{6'h20, 4'd7,  1'b1, 1, 24'h000005, 3};
        vecs[5] = '{6'h00, 4'd15, 1'b1, 1, 24'h000000, 0};
        vecs[6] = '{6'h3F, 4'd15, 1'b0, 6, 24'h543210, 6};
        vecs[7] = '{6'h3F, 4'd15, 1'b1, 6, 24'h543210, 6};

        // Reset state and first dark slot
        #12;
        check("reset_state", obs, exp_vec(0, 0, 0, 7'h00, 1'b0));
        step();
        rst_n = 1'b1;
        check_after_reset("post_reset");
        $display("reset release: first frame tick after 8 clk");

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            i_dig_en  = vecs[i].en;
            i_bright  = vecs[i].bright;
            i_disp_on = vecs[i].disp;
            wait_tick($sformatf("vec%0d_sync", i));
            for (int j = 1; j <= vecs[i].nslots * 8; j++) begin
                int  s, p, dig;
                bit  lit;
                step();
                s   = (j - 1) / 8;
                p   = (j - 1) % 8;
                dig = int'(vecs[i].order[4*s +: 4]);
                lit = vecs[i].disp && (p >= 2) && (p < 2 + vecs[i].lit);
                check($sformatf("vec%0d_j%0d", i, j), obs,
                      exp_vec(dig, lit, j == vecs[i].nslots * 8, seg_of(dig), i_dp[dig]));
            end
            $display("vector %0d: en=%b bright=%0d disp=%0d slots=%0d", i,
                     vecs[i].en, vecs[i].bright, vecs[i].disp, vecs[i].nslots);
        end

        // Brightness change mid-slot only applies from the next slot
        wait_tick("bright_sync");
        for (int j = 1; j <= 16; j++) begin
            int  p, dig, wl;
            step();
            p   = (j - 1) % 8;
            dig = (j - 1) / 8;
            wl  = (j <= 8) ? 6 : 2;
            check($sformatf("bright_mid_j%0d", j), obs,
                  exp_vec(dig, (p >= 2) && (p < 2 + wl), 0, seg_of(dig), i_dp[dig]));
            if (j == 4) i_bright = 4'd5;
        end
        i_bright = 4'd15;
        $display("brightness mid-slot change checked");

        // Display-off takes effect on the next clock
        wait_tick("disp_sync");
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("disp_j%0d", j), obs,
                  exp_vec(0, (j >= 3) && (j != 5), 0, seg_of(0), i_dp[0]));
            if (j == 4) i_disp_on = 1'b0;
            if (j == 5) i_disp_on = 1'b1;
        end
        $display("display off/on checked");

        // Tear-free: digit 3 changed while digit 1 is shown stays old until next frame
        wait_tick("tear_sync");
        for (int f = 0; f < 2; f++) begin
            for (int j = 1; j <= 48; j++) begin
                int         p, dig;
                logic [6:0] sx;
                step();
                p   = (j - 1) % 8;
                dig = (j - 1) / 8;
                sx  = (f == 1 && dig == 3) ? 7'h7F : seg_of(dig);
                check($sformatf("tear_f%0d_j%0d", f, j), obs,
                      exp_vec(dig, p >= 2, j == 48, sx, i_dp[dig]));
                if (f == 0 && j == 12) i_dig_seg[21 +: 7] = 7'h7F;
            end
        end
        $display("tear-free snapshot checked");

        // Asynchronous reset in the middle of a lit slot
        wait_tick("rst_sync");
        for (int j = 1; j <= 3; j++) step();
        check("pre_reset_lit", obs, exp_vec(0, 1, 0, seg_of(0), i_dp[0]));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs, exp_vec(0, 0, 0, 7'h00, 1'b0));
        step();
        step();
        check("reset_hold", obs, exp_vec(0, 0, 0, 7'h00, 1'b0));
        rst_n = 1'b1;
        check_after_reset("mid_reset");
        $display("mid-slot asynchronous reset checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
